// File: rtl/reg_status_scoreboard_pkg.sv
// Shared types and constants for the register result-status table (RST).
// Optional feature macro: RST_WB_BYPASS_EN (same-cycle writeback bypass).
package reg_status_scoreboard_pkg;

  // Tag width for a given number of producing FUs, never below one bit
  function automatic int unsigned tag_width(input int unsigned nfu);
    return (nfu > 1) ? int'($clog2(nfu)) : 1;
  endfunction

  localparam int unsigned RST_S_NREGS = 32;
  localparam int unsigned RST_M_NREGS = 16;
  localparam int unsigned RST_NFU     = 4;
  localparam int unsigned RST_TAG_W   = tag_width(RST_NFU);

  // One table row: producing FU tag plus pending flag
  typedef struct packed {
    logic [RST_TAG_W-1:0] tag;
    logic                 busy;
  } rst_row_t;

  typedef rst_row_t [RST_S_NREGS-1:0] rst_s_t;
  typedef rst_row_t [RST_M_NREGS-1:0] rst_m_t;

endpackage

// File: rtl/reg_status_scoreboard_wb_match.sv
// Per-channel writeback matcher: turns one writeback into a one-hot release
// vector when it hits a busy entry with the same tag, otherwise flags it stale.
module rst_wb_match #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [NREGS-1:0]  busy,
  input  logic [TAG_W-1:0]  tag [NREGS],
  output logic [NREGS-1:0]  rel_c,
  output logic              stale_c
);

  logic hit;

  // Match against current state; a miss on a valid writeback is stale
  always_comb begin
    hit     = wb_valid && busy[wb_rd] && (tag[wb_rd] == wb_tag);
    rel_c   = '0;
    if (hit) begin
      rel_c[wb_rd] = 1'b1;
    end
    stale_c = wb_valid && !hit;
  end

endmodule

// File: rtl/reg_status_scoreboard.sv
// Register result-status table: per-register busy bit and producer tag,
// RAW source lookup, WAW dispatch stall, multi-channel writeback release.
// Optional macro RST_WB_BYPASS_EN: lookups and dispatch see same-cycle releases.
module reg_status_scoreboard
  import reg_status_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS   = RST_S_NREGS,
  parameter int unsigned NFU     = RST_NFU,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned NWB     = 2,
  parameter bit          R0_ZERO = 1'b1,
  localparam int unsigned RIDX_W = $clog2(NREGS),
  localparam int unsigned TAG_W  = tag_width(NFU),
  localparam int unsigned CNT_W  = RIDX_W + 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic                   disp_rd_en,
  input  logic [RIDX_W-1:0]      disp_rd,
  input  logic [TAG_W-1:0]       disp_tag,
  input  logic [NSRC*RIDX_W-1:0] src_idx,
  output logic [NSRC-1:0]        src_busy,
  output logic [NSRC*TAG_W-1:0]  src_tag,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*RIDX_W-1:0]  wb_rd,
  input  logic [NWB*TAG_W-1:0]   wb_tag,
  output logic [CNT_W-1:0]       busy_count,
  output logic                   wb_stale
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_eff_c;
  logic [NREGS-1:0] rel_any_c;
  logic [TAG_W-1:0] tag_q [NREGS];
  logic [NREGS-1:0] rel_vec [NWB];
  logic [NWB-1:0]   stale_vec;
  logic             stale_any_c;
  logic             rd_zero_c;
  logic             accept_c;
  logic [CNT_W-1:0] count_d;

  // One matcher per writeback channel
  for (genvar k = 0; k < NWB; k++) begin : g_wb
    rst_wb_match #(
      .NREGS  (NREGS),
      .TAG_W  (TAG_W),
      .RIDX_W (RIDX_W)
    ) u_match (
      .wb_valid (wb_valid[k]),
      .wb_rd    (wb_rd[k*RIDX_W +: RIDX_W]),
      .wb_tag   (wb_tag[k*TAG_W +: TAG_W]),
      .busy     (busy_q),
      .tag      (tag_q),
      .rel_c    (rel_vec[k]),
      .stale_c  (stale_vec[k])
    );
  end

  // Merge releases and stale flags across channels (duplicate releases are idempotent)
  always_comb begin
    rel_any_c   = '0;
    stale_any_c = 1'b0;
    for (int unsigned k = 0; k < NWB; k++) begin
      rel_any_c   = rel_any_c | rel_vec[k];
      stale_any_c = stale_any_c | stale_vec[k];
    end
  end

`ifdef RST_WB_BYPASS_EN
  // Same-cycle releases are visible to lookups and the WAW stall
  assign busy_eff_c = busy_q & ~rel_any_c;
`else
  // Only registered state is visible; releases show up a cycle later
  assign busy_eff_c = busy_q;
`endif

  // WAW stall and claim acceptance; reg 0 claims are dropped when hardwired
  always_comb begin
    rd_zero_c  = R0_ZERO && (disp_rd == '0);
    disp_ready = !(disp_rd_en && busy_eff_c[disp_rd]);
    accept_c   = disp_valid && disp_ready && disp_rd_en && !rd_zero_c;
  end

  // Source lookups are purely combinational
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_busy[i]                 = busy_eff_c[src_idx[i*RIDX_W +: RIDX_W]];
    assign src_tag[i*TAG_W +: TAG_W]   = tag_q[src_idx[i*RIDX_W +: RIDX_W]];
  end

  // Next busy state: release, then claim overrides, flush overrides all
  always_comb begin
    busy_d = busy_q & ~rel_any_c;
    if (accept_c) begin
      busy_d[disp_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    count_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      count_d = count_d + CNT_W'(busy_d[RIDX_W'(r)]);
    end
  end

  // Busy bits, occupancy count and stale pulse
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q     <= '0;
      busy_count <= '0;
      wb_stale   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
      wb_stale   <= stale_any_c && !flush;
    end
  end

  // Producer tags: written on accepted claims only, untouched by flush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        tag_q[RIDX_W'(r)] <= '0;
      end
    end else if (accept_c && !flush) begin
      tag_q[disp_rd] <= disp_tag;
    end
  end

endmodule

// File: tb/tb_reg_status_scoreboard.sv
// Self-checking bench for reg_status_scoreboard (scalar configuration).
module tb_reg_status_scoreboard;

  localparam int NREGS  = 32;
  localparam int RIDX_W = 5;
  localparam int TAG_W  = 2;
  localparam int NSRC   = 3;
  localparam int NWB    = 2;
`ifdef RST_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   CLK = 1'b0;
  logic                   nRST = 1'b0;
  logic                   flush = 1'b0;
  logic                   disp_valid = 1'b0;
  logic                   disp_ready;
  logic                   disp_rd_en = 1'b0;
  logic [RIDX_W-1:0]      disp_rd = '0;
  logic [TAG_W-1:0]       disp_tag = '0;
  logic [NSRC*RIDX_W-1:0] src_idx = '0;
  logic [NSRC-1:0]        src_busy;
  logic [NSRC*TAG_W-1:0]  src_tag;
  logic [NWB-1:0]         wb_valid = '0;
  logic [NWB*RIDX_W-1:0]  wb_rd = '0;
  logic [NWB*TAG_W-1:0]   wb_tag = '0;
  logic [RIDX_W:0]        busy_count;
  logic                   wb_stale;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  reg_status_scoreboard #(
    .NREGS(NREGS), .NFU(4), .NSRC(NSRC), .NWB(NWB), .R0_ZERO(1'b1)
  ) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rd_en(disp_rd_en), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .src_idx(src_idx), .src_busy(src_busy), .src_tag(src_tag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .busy_count(busy_count), .wb_stale(wb_stale)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit       busy_m [NREGS];
  bit [1:0] tag_m  [NREGS];
  int       cnt_m;
  bit       stale_m;

  function automatic int wbr(input int k);
    return int'(wb_rd[k*RIDX_W +: RIDX_W]);
  endfunction

  function automatic int wbt(input int k);
    return int'(wb_tag[k*TAG_W +: TAG_W]);
  endfunction

  function automatic int srci(input int i);
    return int'(src_idx[i*RIDX_W +: RIDX_W]);
  endfunction

  // Pending as seen by a lookup this cycle
  function automatic bit eff(input int r);
    bit b;
    b = busy_m[r];
    if (BYP) begin
      for (int k = 0; k < NWB; k++)
        if (wb_valid[k] && wbr(k) == r && busy_m[r] && int'(tag_m[r]) == wbt(k)) b = 1'b0;
    end
    return b;
  endfunction

  always @(posedge CLK or negedge nRST) begin : model
    bit nb [NREGS];
    bit st;
    int r;
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin busy_m[i] = 1'b0; tag_m[i] = 2'd0; end
      cnt_m = 0; stale_m = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) busy_m[i] = 1'b0;
      cnt_m = 0; stale_m = 1'b0;
    end else begin
      nb = busy_m;
      st = 1'b0;
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k]) begin
          r = wbr(k);
          if (busy_m[r] && int'(tag_m[r]) == wbt(k)) nb[r] = 1'b0;
          else st = 1'b1;
        end
      end
      r = int'(disp_rd);
      if (disp_valid && disp_rd_en && r != 0 && !eff(r)) begin
        nb[r] = 1'b1;
        tag_m[r] = disp_tag;
      end
      busy_m = nb;
      cnt_m = 0;
      for (int i = 0; i < NREGS; i++) cnt_m += int'(busy_m[i]);
      stale_m = st;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (nRST && chk_en) begin
      for (int i = 0; i < NSRC; i++) begin
        chk($sformatf("src_busy%0d", i), int'(src_busy[i]), int'(eff(srci(i))));
        chk($sformatf("src_tag%0d", i), int'(src_tag[i*TAG_W +: TAG_W]), int'(tag_m[srci(i)]));
      end
      chk("disp_ready", int'(disp_ready), int'(!(disp_rd_en && eff(int'(disp_rd)))));
      chk("busy_count", int'(busy_count), cnt_m);
      chk("wb_stale", int'(wb_stale), int'(stale_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic claim(input int r, input int t);
    disp_valid = 1'b1; disp_rd_en = 1'b1;
    disp_rd = RIDX_W'(r); disp_tag = TAG_W'(t);
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0; disp_rd_en = 1'b0; disp_rd = '0; disp_tag = '0;
  endtask

  task automatic wb(input int k, input int r, input int t);
    wb_valid[k] = 1'b1;
    wb_rd[k*RIDX_W +: RIDX_W] = RIDX_W'(r);
    wb_tag[k*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic wb_off();
    wb_valid = '0;
  endtask

  task automatic set_src(input int i, input int r);
    src_idx[i*RIDX_W +: RIDX_W] = RIDX_W'(r);
  endtask

  function automatic int stag(input int i);
    return int'(src_tag[i*TAG_W +: TAG_W]);
  endfunction

  initial begin
    int r, t;
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    chk_en = 1'b1;

    // Reset state, then claim rd=5 tag=2
    claim(5, 2); set_src(0, 5);
    mid();
    chk("rst_count", int'(busy_count), 0);
    chk("rst_stale", int'(wb_stale), 0);
    chk("rst_ready", int'(disp_ready), 1);
    tick(); claim(5, 3);
    mid();
    chk("claim5_busy", int'(src_busy[0]), 1);
    chk("claim5_tag", stag(0), 2);
    chk("claim5_count", int'(busy_count), 1);
    chk("waw_ready", int'(disp_ready), 0);
    tick(); idle_disp(); wb(0, 5, 1);
    mid();
    chk("waw_tag_kept", stag(0), 2);

    // Stale writeback, then matching writeback
    tick(); wb_off();
    mid();
    chk("stale_pulse", int'(wb_stale), 1);
    chk("stale_busy", int'(src_busy[0]), 1);
    tick(); wb(0, 5, 2);
    mid();
    chk("stale_gone", int'(wb_stale), 0);
    chk("wb_same_cycle_busy", int'(src_busy[0]), BYP ? 0 : 1);
    tick(); wb_off();
    mid();
    chk("released_busy", int'(src_busy[0]), 0);
    chk("released_count", int'(busy_count), 0);

    // Claim and release of the same register in one cycle
    tick(); claim(7, 1); set_src(1, 7);
    tick(); claim(7, 3); wb(0, 7, 1);
    mid();
    chk("collide_ready", int'(disp_ready), BYP ? 1 : 0);
    tick(); idle_disp(); wb_off();
    mid();
    chk("collide_busy", int'(src_busy[1]), BYP ? 1 : 0);
    chk("collide_tag", stag(1), BYP ? 3 : 1);
    chk("collide_stale", int'(wb_stale), 0);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    mid();
    chk("flush1_count", int'(busy_count), 0);

    // Dual-channel releases
    tick(); claim(3, 0); set_src(0, 3); set_src(2, 9);
    tick(); claim(9, 1);
    tick(); idle_disp(); wb(0, 3, 0); wb(1, 9, 1);
    mid();
    chk("dual_pre_count", int'(busy_count), 2);
    tick(); wb_off(); claim(4, 1);
    mid();
    chk("dual_count", int'(busy_count), 0);
    chk("dual_stale", int'(wb_stale), 0);
    tick(); idle_disp(); wb(0, 4, 1); wb(1, 4, 1);
    mid();
    chk("same_pre_count", int'(busy_count), 1);
    tick(); wb_off();
    mid();
    chk("same_count", int'(busy_count), 0);
    chk("same_stale", int'(wb_stale), 0);

    // Register 0 hardwired, then flush with ten busy
    tick(); claim(0, 2); set_src(2, 0);
    mid();
    chk("r0_ready", int'(disp_ready), 1);
    tick(); idle_disp();
    mid();
    chk("r0_count", int'(busy_count), 0);
    chk("r0_busy", int'(src_busy[2]), 0);
    for (int i = 1; i <= 10; i++) begin
      tick(); claim(i, i % 4);
    end
    tick(); idle_disp();
    mid();
    chk("ten_count", int'(busy_count), 10);
    tick(); flush = 1'b1; claim(11, 1); wb(0, 1, 1); set_src(0, 11);
    tick(); flush = 1'b0; idle_disp(); wb_off();
    mid();
    chk("flush_count", int'(busy_count), 0);
    chk("flush_claim_ignored", int'(src_busy[0]), 0);
    chk("flush_stale", int'(wb_stale), 0);

    // Asynchronous reset in the middle of a claim
    tick(); claim(12, 1); set_src(0, 12); set_src(1, 12);
    tick(); claim(12, 2);
    mid();
    chk("prereset_ready", int'(disp_ready), 0);
    #2 nRST = 1'b0;
    #1;
    chk("reset_src_busy", int'(src_busy), 0);
    chk("reset_count", int'(busy_count), 0);
    chk("reset_ready", int'(disp_ready), 1);
    tick(); nRST = 1'b1; idle_disp();
    mid();
    chk("post_reset_count", int'(busy_count), 0);

    // Mixed traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      tick();
      flush      = ($urandom_range(0, 39) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_rd_en = ($urandom_range(0, 3) != 0);
      disp_rd    = RIDX_W'($urandom_range(0, NREGS - 1));
      disp_tag   = TAG_W'($urandom_range(0, 3));
      for (int i = 0; i < NSRC; i++)
        set_src(i, ($urandom_range(0, 2) == 0) ? int'(disp_rd) : int'($urandom_range(0, NREGS - 1)));
      for (int k = 0; k < NWB; k++) begin
        wb_valid[k] = $urandom_range(0, 1);
        r = $urandom_range(0, NREGS - 1);
        t = ($urandom_range(0, 3) != 0) ? int'(tag_m[r]) : int'($urandom_range(0, 3));
        wb_rd[k*RIDX_W +: RIDX_W] = RIDX_W'(r);
        wb_tag[k*TAG_W +: TAG_W] = TAG_W'(t);
      end
    end
    tick(); flush = 1'b0; idle_disp(); wb_off();
    mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
